// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Holds the scan-code prefixes, the arrow make codes and the frame FSM state type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // A PS/2 frame carries odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{parity, data};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Bundle of PS/2 pad inputs and key-event outputs for the receiver.
// Handshake: key_en is a one-cycle strobe; key_in/key_ext/key_break are valid in that cycle and held until the next strobe (no ready, the consumer must not stall).
interface ps2_key_receiver_if;
  import ps2_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_in;
  logic       key_en;
  logic       key_ext;
  logic       key_break;
  logic       frame_err;
  rx_state_t  dbg_state;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_in,
    output key_en,
    output key_ext,
    output key_break,
    output frame_err,
    output dbg_state
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_in,
    input  key_en,
    input  key_ext,
    input  key_break,
    input  frame_err,
    input  dbg_state
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: synchronizers, ps2_clk glitch filter, frame FSM and timeout.
// Produces one byte_valid strobe per good frame and one frame_err strobe per bad or stalled frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output rx_state_t  o_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_dat_s1;
  logic            r_dat_s2;
  logic            r_clk_f;
  logic            r_clk_f_d;
  logic [7:0]      r_flt_cnt;
  logic [TO_W-1:0] r_to_cnt;
  rx_state_t       r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_parity;
  logic [7:0]      r_byte;
  logic            r_byte_valid;
  logic            r_frame_err;

  logic            w_fall;
  logic            w_timeout;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock only follows the pad after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clk_f   <= 1'b1;
      r_clk_f_d <= 1'b1;
      r_flt_cnt <= 8'd0;
    end else begin
      r_clk_f_d <= r_clk_f;
      if (r_clk_s2 != r_clk_f) begin
        if (r_flt_cnt == 8'(FILTER_LEN - 1)) begin
          r_clk_f   <= r_clk_s2;
          r_flt_cnt <= 8'd0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 8'd1;
        end
      end else begin
        r_flt_cnt <= 8'd0;
      end
    end
  end

  assign w_fall    = r_clk_f_d & ~r_clk_f;
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == IDLE) || w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // A fall in the same cycle as the timeout limit takes priority and keeps the frame alive.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= IDLE;
      r_shift      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_parity     <= 1'b0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= STOP;
          end
          STOP: begin
            if (r_dat_s2 && odd_parity_ok(r_shift, r_parity)) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_timeout) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_state      = r_state;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver for the VGA controller: deframes bytes and folds E0/F0 prefixes
// into key_ext/key_break, emitting one key_en strobe per make code (and break code if enabled).
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter bit EMIT_BREAK  = 1'b0
) (
  input logic              iVGA_CLK,
  input logic              iRST_n,
  ps2_key_receiver_if.master bus
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;
  rx_state_t  w_state;

  logic [7:0] r_key_in;
  logic       r_key_en;
  logic       r_key_ext;
  logic       r_key_break;
  logic       r_frame_err;
  logic       r_ext_pend;
  logic       r_brk_pend;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .iVGA_CLK     (iVGA_CLK),
    .iRST_n       (iRST_n),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_state      (w_state)
  );

  // Prefix bytes only arm flags; the next non-prefix byte consumes them whether or not it is emitted.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_key_in    <= 8'd0;
      r_key_en    <= 1'b0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_frame_err <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
    end else begin
      r_key_en    <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_frame_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == PS2_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte == PS2_BRK) begin
          r_brk_pend <= 1'b1;
        end else begin
          if (!r_brk_pend || EMIT_BREAK) begin
            r_key_in    <= w_byte;
            r_key_ext   <= r_ext_pend;
            r_key_break <= r_brk_pend;
            r_key_en    <= 1'b1;
          end
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.key_in    = r_key_in;
  assign bus.key_en    = r_key_en;
  assign bus.key_ext   = r_key_ext;
  assign bus.key_break = r_key_break;
  assign bus.frame_err = r_frame_err;
  assign bus.dbg_state = w_state;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: two instances (break suppressed / emitted) share one PS/2 line pair,
// and every event is compared against a prefix-tracking model of the scan-code stream.
module tb_ps2_key_receiver;
  import ps2_pkg::*;

  localparam int FLT = 8;
  localparam int TO  = 400;
  localparam int W   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic r_ps2_clk = 1'b1;
  logic r_ps2_data = 1'b1;

  ps2_key_receiver_if bus0 ();
  ps2_key_receiver_if bus1 ();

  assign bus0.ps2_clk  = r_ps2_clk;
  assign bus0.ps2_data = r_ps2_data;
  assign bus1.ps2_clk  = r_ps2_clk;
  assign bus1.ps2_data = r_ps2_data;

  ps2_key_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO), .EMIT_BREAK(1'b0)) dut0 (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus0.master)
  );

  ps2_key_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO), .EMIT_BREAK(1'b1)) dut1 (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus1.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_en_cyc = 0;
  int err_n0 = 0;
  int err_n1 = 0;
  int exp_err = 0;

  logic [W-1:0] obs_q0[$];
  logic [W-1:0] obs_q1[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] last_exp[2];
  bit ext_p[2];
  bit brk_p[2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus0.key_en) begin
      obs_q0.push_back({bus0.key_ext, bus0.key_break, bus0.key_in});
      last_en_cyc = cyc;
    end
    if (bus1.key_en) obs_q1.push_back({bus1.key_ext, bus1.key_break, bus1.key_in});
    if (bus0.frame_err) err_n0++;
    if (bus1.frame_err) err_n1++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a byte stream with E0/F0 prefixes; instance 0 drops break codes, instance 1 keeps them.
  function automatic void model_byte(input logic [7:0] b);
    for (int d = 0; d < 2; d++) begin
      if (b == PS2_EXT) ext_p[d] = 1'b1;
      else if (b == PS2_BRK) brk_p[d] = 1'b1;
      else begin
        if (!(brk_p[d] && d == 0)) begin
          last_exp[d] = {ext_p[d], brk_p[d], b};
          if (d == 0) exp_q0.push_back(last_exp[d]);
          else exp_q1.push_back(last_exp[d]);
        end
        ext_p[d] = 1'b0;
        brk_p[d] = 1'b0;
      end
    end
  endfunction

  function automatic void model_err();
    exp_err++;
    for (int d = 0; d < 2; d++) begin
      ext_p[d] = 1'b0;
      brk_p[d] = 1'b0;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input int half, input bit glitch);
    r_ps2_data = b;
    if (glitch) begin
      tick(14);
      r_ps2_clk = 1'b0;
      tick(3);
      r_ps2_clk = 1'b1;
      tick(half - 17);
    end else begin
      tick(half);
    end
    r_ps2_clk = 1'b0;
    stop_cyc = cyc;
    tick(half);
    r_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input logic stop, input int glitch_bit);
    logic [10:0] f;
    int half;
    half = $urandom_range(24, 30);
    f = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], half, (i == glitch_bit));
    tick(half);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, -1);
    model_byte(b);
  endtask

  task automatic check_out(input string tag);
    tick(40);
    chk({tag, "_cnt0"}, obs_q0.size(), exp_q0.size());
    chk({tag, "_cnt1"}, obs_q1.size(), exp_q1.size());
    while (obs_q0.size() > 0 && exp_q0.size() > 0) chk({tag, "_ev0"}, obs_q0.pop_front(), exp_q0.pop_front());
    while (obs_q1.size() > 0 && exp_q1.size() > 0) chk({tag, "_ev1"}, obs_q1.pop_front(), exp_q1.pop_front());
    obs_q0.delete(); obs_q1.delete(); exp_q0.delete(); exp_q1.delete();
    chk({tag, "_hold0"}, {bus0.key_ext, bus0.key_break, bus0.key_in}, last_exp[0]);
    chk({tag, "_hold1"}, {bus1.key_ext, bus1.key_break, bus1.key_in}, last_exp[1]);
    chk({tag, "_err0"}, err_n0, exp_err);
    chk({tag, "_err1"}, err_n1, exp_err);
  endtask

  initial begin
    last_exp[0] = '0;
    last_exp[1] = '0;

    // Reset with random pad activity
    for (int i = 0; i < 200; i++) begin
      r_ps2_clk  = 1'($urandom_range(0, 1));
      r_ps2_data = 1'($urandom_range(0, 1));
      tick(1);
      if (i % 50 == 49) begin
        chk("rst_out0", {bus0.key_in, bus0.key_en, bus0.key_ext, bus0.key_break, bus0.frame_err}, 32'd0);
        chk("rst_out1", {bus1.key_in, bus1.key_en, bus1.key_ext, bus1.key_break, bus1.frame_err}, 32'd0);
      end
    end
    r_ps2_clk  = 1'b1;
    r_ps2_data = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(100);
    chk("rst_state", 32'(bus0.dbg_state), 32'(IDLE));
    check_out("idle");

    // Plain make code with latency measurement
    good_frame(8'h1C);
    check_out("make");
    chk("latency", last_en_cyc - stop_cyc, 2 + FLT + 2);

    // Extended make code
    good_frame(PS2_EXT);
    check_out("ext_pfx");
    good_frame(KEY_LEFT);
    check_out("ext_make");

    // Extended break, then extended make
    good_frame(PS2_EXT);
    good_frame(PS2_BRK);
    good_frame(KEY_LEFT);
    check_out("ext_break");
    good_frame(PS2_EXT);
    good_frame(KEY_RIGHT);
    check_out("after_break");

    // Bad parity, bad stop, glitch
    send_frame(KEY_LEFT, 1'b1, 1'b1, -1);
    model_err();
    check_out("parity");
    good_frame(PS2_EXT);
    send_frame(KEY_DOWN, 1'b0, 1'b0, -1);
    model_err();
    check_out("stop");
    send_frame(KEY_UP, 1'b0, 1'b1, 4);
    model_byte(KEY_UP);
    check_out("glitch");

    // Timeout after start + 4 data bits
    good_frame(PS2_EXT);
    ps2_bit(1'b0, 26, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 26, 1'b0);
    tick(TO + 60);
    model_err();
    chk("tmo_state", 32'(bus0.dbg_state), 32'(IDLE));
    check_out("timeout");
    good_frame(KEY_UP);
    check_out("post_tmo");

    // Random stream
    for (int n = 0; n < 20; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      b = 8'($urandom_range(0, 255));
      if (r < 25) b = PS2_EXT;
      else if (r < 40) b = PS2_BRK;
      if ($urandom_range(0, 9) == 0) begin
        send_frame(b, 1'b1, 1'b1, -1);
        model_err();
      end else begin
        good_frame(b);
      end
      check_out("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
